id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the MIPS core. It captures the two register-file read operands, immediate, register specifiers and decoded control bundle into the ID/EX pipeline register. It detects load-use hazards against the instruction currently in EX and inserts bubbles while stalling upstream. It also honours branch flush and downstream freeze requests, and keeps a saturating count of load-use bubbles.

## Interface
- WIDTH, 32, datapath width (matches `WIDTH)
- CNT_W, 16, width of bubble counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt, id_rd  in  5 each  register specifiers from decode
- id_data1, id_data2  in  WIDTH  register-file read data for rs, rt
- id_imm  in  WIDTH  sign/zero-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle (package layout)
- flush  in  1  branch/jump resolved taken in EX; squash ID
- ext_stall  in  1  downstream freeze; hold ID/EX contents
- ex_valid  out  1  ID/EX entry is a real instruction
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- ex_data1, ex_data2, ex_imm  out  WIDTH  registered operands
- ex_ctrl  out  CTRL_W  registered control bundle
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- hazard = id_valid & ex_valid & ex_ctrl.memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- stall_o = ~flush & (hazard | ext_stall).
- Per rising edge, priority high to low:
  - rst==0: all outputs 0, including ex_valid, ex_ctrl and bubble_cnt.
  - flush: load bubble (ex_valid=0, ex_ctrl=0, specifiers/data/imm=0). Counter unchanged.
  - ext_stall: hold every ID/EX field. Hazard is not counted.
  - hazard: load bubble; bubble_cnt += 1, saturating at all-ones.
  - else: load all id_* fields. ex_valid=id_valid. ex_ctrl=id_ctrl when id_valid, else 0.
- A bubble never carries regwrite, memwrite or memread. Downstream stages rely on ex_ctrl being zero whenever ex_valid=0.
- The register file writes on the falling edge, so id_data1/id_data2 already reflect a same-cycle WB write. No WB bypass is needed here.
- Register 0 never creates a hazard.

## Timing
- Latency 1 cycle: ID values appear on ex_* after the next rising edge.
- stall_o is same-cycle combinational from ex_* regs, id_* specifiers, flush and ext_stall. There is no registered path.
- A load-use produces exactly one bubble. On the following cycle ex_ctrl.memread=0, so hazard clears and the held instruction loads.
- flush together with hazard: flush wins, stall_o=0, no count.
- flush together with ext_stall: flush wins, and the register is bubbled.
- Reset asserted mid-stall: next edge clears everything, and stall_o is 0 once ex_valid=0.
- Counter saturates: at 2^CNT_W-1 it stays there.

## Structure
- Shared package pipe_pkg holds:
  - CTRL_W = 11.
  - Control bundle field offsets: regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst, aluop[3:0].
  - ZERO_CTRL constant.
- Sub-module load_use_detect: purely combinational hazard compare. The rest, i.e. the pipeline register, priority mux and counter, lives in id_ex_stage.

## Test plan
- Reset: hold rst=0 two cycles with id_valid=1 and random data → all ex_* = 0, stall_o=0, bubble_cnt=0.
- Normal pass: id_rs=3, id_rt=4, id_rd=5, data1=0x11, data2=0x22, imm=0xFFFF_FFF0, ctrl regwrite → next cycle identical values appear on ex_*, ex_valid=1.
- Load-use: lw writing $8 in EX, then ID add with rs=8 → stall_o=1 that cycle. Next cycle ex_valid=0 and ex_ctrl=0, bubble_cnt=1. The add then enters the following cycle.
- $0 and flush: lw to $0 then use of $0 → no stall. lw $8 plus dependent ID with flush=1 → stall_o=0, bubble loaded, bubble_cnt unchanged.
- ext_stall: assert for 3 cycles with changing id_* → ex_* frozen at the pre-stall value, stall_o=1. Release → the current ID value loads.
- Saturation with CNT_W=2: force 5 consecutive load-use hazards → bubble_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MIPS core.
// Control bundle layout and constants used by decode and execute stages.
package pipe_pkg;

    localparam int CTRL_W = 11;

    localparam int CTRL_REGWRITE = 10;
    localparam int CTRL_MEMTOREG = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUOP    = 0;
    localparam int ALUOP_W       = 4;

    localparam logic [CTRL_W-1:0] ZERO_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
// Purely combinational; register 0 never matches.
module load_use_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rt == id_rs);
    assign rt_hit = (ex_rt == id_rt);

    assign hazard = id_valid & ex_valid & ex_memread
                  & (ex_rt != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, flush, freeze
// and a saturating bubble counter.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [WIDTH-1:0]  id_data1,
    input  logic [WIDTH-1:0]  id_data2,
    input  logic [WIDTH-1:0]  id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [WIDTH-1:0]  ex_data1,
    output logic [WIDTH-1:0]  ex_data2,
    output logic [WIDTH-1:0]  ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic hazard;

    load_use_detect u_lud (
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (ex_valid),
        .ex_memread (ex_ctrl[CTRL_MEMREAD]),
        .ex_rt      (ex_rt),
        .hazard     (hazard)
    );

    assign stall_o = ~flush & (hazard | ext_stall);

    // Conditions overlap (flush with ext_stall/hazard), so order matters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= ZERO_CTRL;
        end else begin
            priority case (1'b1)
                flush, (!ext_stall && hazard): begin
                    ex_valid <= 1'b0;
                    ex_rs    <= '0;
                    ex_rt    <= '0;
                    ex_rd    <= '0;
                    ex_data1 <= '0;
                    ex_data2 <= '0;
                    ex_imm   <= '0;
                    ex_ctrl  <= ZERO_CTRL;
                end
                ext_stall: begin
                end
                default: begin
                    ex_valid <= id_valid;
                    ex_rs    <= id_rs;
                    ex_rt    <= id_rt;
                    ex_rd    <= id_rd;
                    ex_data1 <= id_data1;
                    ex_data2 <= id_data2;
                    ex_imm   <= id_imm;
                    ex_ctrl  <= id_valid ? id_ctrl : ZERO_CTRL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!flush && !ext_stall && hazard
                     && bubble_cnt != '1) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage.
// Two instances (16-bit and 2-bit counters) share all inputs.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [W-1:0]      id_data1, id_data2, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              flush, ext_stall;

    logic              ex_valid;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [W-1:0]      ex_data1, ex_data2, ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall_o;
    logic [15:0]       bubble_cnt;

    logic              s_valid;
    logic [4:0]        s_rs, s_rt, s_rd;
    logic [W-1:0]      s_data1, s_data2, s_imm;
    logic [CTRL_W-1:0] s_ctrl;
    logic              s_stall;
    logic [1:0]        s_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit              valid;
        bit [4:0]        rs, rt, rd;
        bit [W-1:0]      d1, d2, imm;
        bit [CTRL_W-1:0] ctrl;
    } ex_m_t;

    ex_m_t m;
    int    m_cnt16;
    int    m_cnt2;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_data1(id_data1), .id_data2(id_data2),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .flush(flush), .ext_stall(ext_stall),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall_o(stall_o), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.WIDTH(W), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_data1(id_data1), .id_data2(id_data2),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .flush(flush), .ext_stall(ext_stall),
        .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt),
        .ex_rd(s_rd), .ex_data1(s_data1), .ex_data2(s_data2),
        .ex_imm(s_imm), .ex_ctrl(s_ctrl),
        .stall_o(s_stall), .bubble_cnt(s_cnt)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        return id_valid && m.valid && m.ctrl[CTRL_MEMREAD]
            && m.rt != 0 && (m.rt == id_rs || m.rt == id_rt);
    endfunction

    function automatic ex_m_t bubble();
        ex_m_t b;
        b = '{default: '0};
        return b;
    endfunction

    task automatic model_edge();
        bit hz;
        hz = model_hazard();
        if (!rst) begin
            m = bubble();
            m_cnt16 = 0;
            m_cnt2 = 0;
        end else if (flush) begin
            m = bubble();
        end else if (ext_stall) begin
        end else if (hz) begin
            m = bubble();
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end else begin
            m.valid = id_valid;
            m.rs = id_rs;
            m.rt = id_rt;
            m.rd = id_rd;
            m.d1 = id_data1;
            m.d2 = id_data2;
            m.imm = id_imm;
            m.ctrl = id_valid ? id_ctrl : '0;
        end
    endtask

    // Called just after a negedge with inputs already applied.
    task automatic cycle();
        bit exp_stall;
        #1;
        exp_stall = !flush && (model_hazard() || ext_stall);
        chk("stall_o", 64'(stall_o), 64'(exp_stall));
        model_edge();
        @(posedge clk);
        #1;
        chk("ex_valid", 64'(ex_valid), 64'(m.valid));
        chk("ex_rs", 64'(ex_rs), 64'(m.rs));
        chk("ex_rt", 64'(ex_rt), 64'(m.rt));
        chk("ex_rd", 64'(ex_rd), 64'(m.rd));
        chk("ex_data1", 64'(ex_data1), 64'(m.d1));
        chk("ex_data2", 64'(ex_data2), 64'(m.d2));
        chk("ex_imm", 64'(ex_imm), 64'(m.imm));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt16));
        chk("s_cnt", 64'(s_cnt), 64'(m_cnt2));
        chk("s_valid", 64'(s_valid), 64'(m.valid));
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit [4:0] rs,
                         input bit [4:0] rt, input bit [4:0] rd,
                         input bit [CTRL_W-1:0] c,
                         input bit fl, input bit es);
        id_valid = v;
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
        id_data1 = $urandom;
        id_data2 = $urandom;
        id_imm = $urandom;
        id_ctrl = c;
        flush = fl;
        ext_stall = es;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) begin
            drive(1, 5'($urandom), 5'($urandom), 5'($urandom),
                  CTRL_W'($urandom), 0, 0);
            cycle();
        end
        rst = 1'b1;
    endtask

    localparam bit [CTRL_W-1:0] C_LW  =
        (1 << CTRL_MEMREAD) | (1 << CTRL_REGWRITE) | (1 << CTRL_ALUSRC);
    localparam bit [CTRL_W-1:0] C_ADD =
        (1 << CTRL_REGWRITE) | (1 << CTRL_REGDST) | 2;

    initial begin
        m = bubble();
        m_cnt16 = 0;
        m_cnt2 = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        do_reset();
        chk("rst_valid", 64'(ex_valid), 64'(0));
        chk("rst_ctrl", 64'(ex_ctrl), 64'(0));
        chk("rst_cnt", 64'(bubble_cnt), 64'(0));
        chk("rst_stall", 64'(stall_o), 64'(0));

        // Normal pass
        drive(1, 3, 4, 5, 1 << CTRL_REGWRITE, 0, 0);
        id_data1 = 32'h11;
        id_data2 = 32'h22;
        id_imm = 32'hFFFF_FFF0;
        cycle();
        chk("np_data1", 64'(ex_data1), 64'h11);
        chk("np_imm", 64'(ex_imm), 64'hFFFF_FFF0);
        chk("np_valid", 64'(ex_valid), 64'(1));

        // Load-use on $8
        drive(1, 2, 8, 8, C_LW, 0, 0);
        cycle();
        drive(1, 8, 9, 10, C_ADD, 0, 0);
        #1 chk("lu_stall", 64'(stall_o), 64'(1));
        cycle();
        chk("lu_bub_valid", 64'(ex_valid), 64'(0));
        chk("lu_bub_ctrl", 64'(ex_ctrl), 64'(0));
        chk("lu_cnt", 64'(bubble_cnt), 64'(1));
        cycle();
        chk("lu_add_in", 64'(ex_rs), 64'(8));

        // $0 load and flush with hazard
        drive(1, 1, 0, 0, C_LW, 0, 0);
        cycle();
        drive(1, 0, 0, 3, C_ADD, 0, 0);
        #1 chk("r0_stall", 64'(stall_o), 64'(0));
        cycle();
        drive(1, 2, 8, 8, C_LW, 0, 0);
        cycle();
        drive(1, 8, 8, 3, C_ADD, 1, 0);
        #1 chk("fl_stall", 64'(stall_o), 64'(0));
        cycle();
        chk("fl_cnt", 64'(bubble_cnt), 64'(1));

        // ext_stall freeze for 3 cycles
        drive(1, 6, 7, 9, C_ADD, 0, 0);
        cycle();
        repeat (3) begin
            drive(1, 5'($urandom), 5'($urandom), 5'($urandom),
                  CTRL_W'($urandom), 0, 1);
            cycle();
            chk("es_hold_rs", 64'(ex_rs), 64'(6));
        end
        drive(1, 11, 12, 13, C_ADD, 0, 0);
        cycle();
        chk("es_release", 64'(ex_rd), 64'(13));

        // Saturation of the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 8, 8, C_LW, 0, 0);
            cycle();
            drive(1, 8, 2, 3, C_ADD, 0, 0);
            cycle();
            chk("sat_cnt", 64'(s_cnt), 64'(i < 3 ? i + 1 : 3));
        end

        // Random traffic with biased register overlap
        for (int i = 0; i < 600; i++) begin
            bit [CTRL_W-1:0] c;
            c = CTRL_W'($urandom);
            c[CTRL_MEMREAD] = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 31) != 0);
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom), c,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
